// File: rtl/eight_bit_wallace_mac_accumulator_pkg.sv
// Shared definitions for the Wallace tree multiply-accumulate stage.
// Holds the controller state encoding, term-counter sizing, product width
// and the 3:2 carry-save compressor used by the multiplier reduction layers.
package eight_bit_wallace_mac_accumulator_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } mac_state_t;

   localparam int TERM_CNT_W = 9;
   localparam int MAX_TERMS  = 256;
   localparam int PROD_W     = 16;

   // One carry-save layer output: a sum word and a carry word that is
   // already shifted into its destination column.
   typedef struct packed {
      logic [PROD_W-1:0] sum;
      logic [PROD_W-1:0] carry;
   } csa_out_t;

   // Word-wide 3:2 compressor. The carry dropped out of the top column is
   // never set because every 8x8 product fits in PROD_W bits.
   function automatic csa_out_t csa(input logic [PROD_W-1:0] x,
                                    input logic [PROD_W-1:0] y,
                                    input logic [PROD_W-1:0] z);
      csa_out_t          r;
      logic [PROD_W-1:0] maj;
      maj     = (x & y) | (x & z) | (y & z);
      r.sum   = x ^ y ^ z;
      r.carry = {maj[PROD_W-2:0], 1'b0};
      return r;
   endfunction

endpackage

// File: rtl/eight_bit_wallace_tree_multiplier.sv
// Purely combinational 8x8 -> 16 unsigned multiplier.
// Eight partial-product rows are reduced 8 -> 6 -> 4 -> 3 -> 2 through
// carry-save layers, then one carry-propagate add produces the product.
// Ports:
//   a, b     in  8   unsigned operands
//   product  out 16  a * b
module eight_bit_wallace_tree_multiplier
   import eight_bit_wallace_mac_accumulator_pkg::*;
(
   input  logic [7:0]        a,
   input  logic [7:0]        b,
   output logic [PROD_W-1:0] product
);

   logic [PROD_W-1:0] pp [8];
   csa_out_t          l1_0, l1_1, l2_0, l2_1, l3, l4;

   // Partial-product generation: row i is a gated by b[i], shifted by i.
   always_comb begin
      for (int i = 0; i < 8; i++) begin
         pp[i] = {8'd0, (a & {8{b[i]}})} << i;
      end
   end

   // Layer 1: 8 rows -> 6 rows.
   assign l1_0 = csa(pp[0], pp[1], pp[2]);
   assign l1_1 = csa(pp[3], pp[4], pp[5]);
   // Layer 2: 6 rows -> 4 rows.
   assign l2_0 = csa(l1_0.sum, l1_0.carry, l1_1.sum);
   assign l2_1 = csa(l1_1.carry, pp[6], pp[7]);
   // Layer 3: 4 rows -> 3 rows.
   assign l3   = csa(l2_0.sum, l2_0.carry, l2_1.sum);
   // Layer 4: 3 rows -> 2 rows.
   assign l4   = csa(l3.sum, l3.carry, l2_1.carry);

   assign product = l4.sum + l4.carry;

endmodule

// File: rtl/eight_bit_wallace_mac_accumulator.sv
// Multiply-accumulate stage: accepts num_terms operand pairs over a
// valid/ready handshake, registers each Wallace tree product, sums it into
// an ACC_W-bit accumulator and offers the total on a valid/ready port.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   start, num_terms     begin a run of num_terms (0..256) pairs, IDLE only
//   abort                cancel the current run
//   in_valid, in_ready   operand handshake for a, b
//   out_valid, out_ready result handshake for result
//   overflow             sticky carry-out flag for the run
//   busy                 high whenever the controller is not IDLE
module eight_bit_wallace_mac_accumulator
   import eight_bit_wallace_mac_accumulator_pkg::*;
#(
   parameter int ACC_W    = 24,
   parameter bit SATURATE = 1'b1
)
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [TERM_CNT_W-1:0] num_terms,
   input  logic                  abort,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [7:0]            a,
   input  logic [7:0]            b,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [ACC_W-1:0]      result,
   output logic                  overflow,
   output logic                  busy
);

   mac_state_t            state, state_next;
   logic [TERM_CNT_W-1:0] remaining, remaining_next;
   logic [PROD_W-1:0]     product, prod_q;
   logic                  prod_vld, prod_vld_next;
   logic [ACC_W-1:0]      acc, acc_next;
   logic                  overflow_next;
   logic [ACC_W:0]        sum_ext;
   logic                  load_run, abort_eff, accept_eff;

   eight_bit_wallace_tree_multiplier u_mult (
      .a       (a),
      .b       (b),
      .product (product)
   );

   // abort outranks both the operand accept and the result handshake.
   assign abort_eff  = abort & (state != IDLE);
   assign accept_eff = in_valid & in_ready & (state == ACCUM) & ~abort;
   assign sum_ext    = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod_q};
   assign result     = acc;

   // Next-state logic for the run controller.
   always_comb begin
      state_next = state;
      load_run   = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               load_run   = 1'b1;
               state_next = (num_terms == {TERM_CNT_W{1'b0}}) ? DONE : ACCUM;
            end else begin
               state_next = IDLE;
            end
         end
         ACCUM: begin
            if (abort) begin
               state_next = IDLE;
            end else if (accept_eff && (remaining == TERM_CNT_W'(1))) begin
               state_next = DRAIN;
            end else begin
               state_next = ACCUM;
            end
         end
         DRAIN: begin
            if (abort) begin
               state_next = IDLE;
            end else begin
               state_next = DONE;
            end
         end
         DONE: begin
            if (abort || (out_valid && out_ready)) begin
               state_next = IDLE;
            end else begin
               state_next = DONE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Next values for term counter, product-valid flag and accumulator.
   always_comb begin
      remaining_next = remaining;
      prod_vld_next  = 1'b0;
      acc_next       = acc;
      overflow_next  = overflow;
      if (load_run) begin
         remaining_next = num_terms;
         acc_next       = {ACC_W{1'b0}};
         overflow_next  = 1'b0;
      end else if (abort_eff) begin
         // result and overflow freeze; the pending product is discarded
         prod_vld_next = 1'b0;
      end else begin
         if (prod_vld) begin
            if (sum_ext[ACC_W]) begin
               overflow_next = 1'b1;
               acc_next      = SATURATE ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
            end else begin
               acc_next = sum_ext[ACC_W-1:0];
            end
         end else begin
            acc_next = acc;
         end
         if (accept_eff) begin
            remaining_next = remaining - TERM_CNT_W'(1);
            prod_vld_next  = 1'b1;
         end else begin
            remaining_next = remaining;
         end
      end
   end

   // State, datapath and registered handshake/status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         remaining <= {TERM_CNT_W{1'b0}};
         prod_q    <= {PROD_W{1'b0}};
         prod_vld  <= 1'b0;
         acc       <= {ACC_W{1'b0}};
         overflow  <= 1'b0;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state     <= state_next;
         remaining <= remaining_next;
         prod_vld  <= prod_vld_next;
         acc       <= acc_next;
         overflow  <= overflow_next;
         in_ready  <= (state_next == ACCUM) && (remaining_next != {TERM_CNT_W{1'b0}});
         out_valid <= (state_next == DONE);
         busy      <= (state_next != IDLE);
         if (accept_eff) begin
            prod_q <= product;
         end else begin
            prod_q <= prod_q;
         end
      end
   end

endmodule

// File: tb/tb_eight_bit_wallace_mac_accumulator.sv
// Self-checking bench: three instances (24-bit saturating, 16-bit
// saturating, 16-bit wrapping) share stimulus; expected sums come from a
// plain-arithmetic model of the accumulate rules.
module tb_eight_bit_wallace_mac_accumulator;
   import eight_bit_wallace_mac_accumulator_pkg::*;

   logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
   logic in_valid = 1'b0, out_ready = 1'b0;
   logic [8:0] num_terms = 9'd0;
   logic [7:0] a = 8'd0, b = 8'd0;

   logic in_ready, out_valid, overflow, busy;
   logic [23:0] result;
   logic in_ready_s, out_valid_s, overflow_s, busy_s;
   logic [15:0] result_s;
   logic in_ready_w, out_valid_w, overflow_w, busy_w;
   logic [15:0] result_w;

   int n_tests = 0, n_fail = 0;
   int pa [MAX_TERMS];
   int pb [MAX_TERMS];

   always #5 clk = ~clk;

   eight_bit_wallace_mac_accumulator #(.ACC_W(24), .SATURATE(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .num_terms(num_terms), .abort(abort),
      .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .out_valid(out_valid),
      .out_ready(out_ready), .result(result), .overflow(overflow), .busy(busy));

   eight_bit_wallace_mac_accumulator #(.ACC_W(16), .SATURATE(1'b1)) dut16s (
      .clk(clk), .rst_n(rst_n), .start(start), .num_terms(num_terms), .abort(abort),
      .in_valid(in_valid), .in_ready(in_ready_s), .a(a), .b(b), .out_valid(out_valid_s),
      .out_ready(out_ready), .result(result_s), .overflow(overflow_s), .busy(busy_s));

   eight_bit_wallace_mac_accumulator #(.ACC_W(16), .SATURATE(1'b0)) dut16w (
      .clk(clk), .rst_n(rst_n), .start(start), .num_terms(num_terms), .abort(abort),
      .in_valid(in_valid), .in_ready(in_ready_w), .a(a), .b(b), .out_valid(out_valid_w),
      .out_ready(out_ready), .result(result_w), .overflow(overflow_w), .busy(busy_w));

   // Reference: running sum of products, clamped or wrapped at 2^w.
   function automatic void model(input int n, input int w, input bit sat,
                                 output longint res, output bit ovf);
      longint lim;
      lim = longint'(1) << w;
      res = 0;
      ovf = 1'b0;
      for (int i = 0; i < n; i++) begin
         res = res + longint'(pa[i]) * longint'(pb[i]);
         if (res >= lim) begin
            ovf = 1'b1;
            res = sat ? lim - 1 : res - lim;
         end
      end
   endfunction

   // Starts a run and streams pa/pb; lat counts edges from the last accept
   // edge (counted as 1) until out_valid is seen.
   task automatic drive_run(input int n, input bit gaps, output int lat, output bit tmo);
      int  i, cyc;
      bit  take;
      num_terms = 9'(n);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      i = 0;
      cyc = 0;
      while (i < n && cyc < 4000) begin
         if (gaps && $urandom_range(0, 1) == 1) begin
            in_valid = 1'b0;
            a = 8'($urandom);
            b = 8'($urandom);
            repeat ($urandom_range(1, 3)) begin
               @(posedge clk); #1;
               cyc++;
            end
         end
         in_valid = 1'b1;
         a = 8'(pa[i]);
         b = 8'(pb[i]);
         take = in_ready;
         @(posedge clk); #1;
         cyc++;
         if (take) i++;
      end
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      tmo = (i < n) || !out_valid;
   endtask

   task automatic handshake();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      n_tests++;
      if ({in_ready, out_valid, overflow, busy} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_flags: got %b expected 0000", {in_ready, out_valid, overflow, busy});
      end
      n_tests++;
      if (result !== 24'd0) begin
         n_fail++;
         $display("FAIL reset_result: got %0d expected 0", result);
      end
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      n_tests++;
      if ({in_ready, busy, out_valid} !== 3'b000) begin
         n_fail++;
         $display("FAIL idle_after_reset: got %b expected 000", {in_ready, busy, out_valid});
      end
   endtask

   task automatic test_back_to_back();
      int lat;
      bit tmo;
      pa[0] = 255; pb[0] = 255; pa[1] = 2; pb[1] = 3; pa[2] = 0; pb[2] = 200;
      drive_run(3, 1'b0, lat, tmo);
      n_tests++;
      if (tmo !== 1'b0 || lat != 2) begin
         n_fail++;
         $display("FAIL b2b_latency: got lat=%0d tmo=%0d expected lat=2 tmo=0", lat, tmo);
      end
      n_tests++;
      if (result !== 24'd65031 || overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_result: got %0d ovf=%0d expected 65031 ovf=0", result, overflow);
      end
      handshake();
      n_tests++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_release: got ov=%0d busy=%0d expected 0 0", out_valid, busy);
      end
   endtask

   task automatic test_gaps_and_hold();
      int lat;
      bit tmo, held;
      pa[0] = 255; pb[0] = 255; pa[1] = 2; pb[1] = 3; pa[2] = 0; pb[2] = 200;
      drive_run(3, 1'b1, lat, tmo);
      n_tests++;
      if (tmo !== 1'b0 || lat != 2) begin
         n_fail++;
         $display("FAIL gaps_latency: got lat=%0d tmo=%0d expected lat=2 tmo=0", lat, tmo);
      end
      held = 1'b1;
      for (int k = 0; k < 5; k++) begin
         if (out_valid !== 1'b1 || result !== 24'd65031 || overflow !== 1'b0) held = 1'b0;
         @(posedge clk); #1;
      end
      n_tests++;
      if (!held || result !== 24'd65031) begin
         n_fail++;
         $display("FAIL gaps_hold: got %0d ov=%0d expected 65031 held", result, out_valid);
      end
      // start during the handshake cycle must be ignored
      start = 1'b1;
      num_terms = 9'd5;
      handshake();
      start = 1'b0;
      n_tests++;
      if ({out_valid, busy, in_ready} !== 3'b000) begin
         n_fail++;
         $display("FAIL gaps_release: got %b expected 000", {out_valid, busy, in_ready});
      end
   endtask

   task automatic test_saturate();
      int lat;
      bit tmo;
      pa[0] = 255; pb[0] = 255; pa[1] = 255; pb[1] = 255;
      drive_run(2, 1'b0, lat, tmo);
      n_tests++;
      if (tmo !== 1'b0 || result !== 24'd130050 || overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL sat_acc24: got %0d ovf=%0d expected 130050 ovf=0", result, overflow);
      end
      n_tests++;
      if (result_s !== 16'd65535 || overflow_s !== 1'b1) begin
         n_fail++;
         $display("FAIL sat_clamp16: got %0d ovf=%0d expected 65535 ovf=1", result_s, overflow_s);
      end
      n_tests++;
      if (result_w !== 16'd64514 || overflow_w !== 1'b1) begin
         n_fail++;
         $display("FAIL sat_wrap16: got %0d ovf=%0d expected 64514 ovf=1", result_w, overflow_w);
      end
      handshake();
   endtask

   task automatic test_zero_terms();
      num_terms = 9'd0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n_tests++;
      if (out_valid !== 1'b1 || result !== 24'd0 || in_ready !== 1'b0 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL zero_terms: got ov=%0d res=%0d ir=%0d busy=%0d expected 1 0 0 1",
                  out_valid, result, in_ready, busy);
      end
      handshake();
      n_tests++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL zero_release: got ov=%0d ir=%0d expected 0 0", out_valid, in_ready);
      end
   endtask

   task automatic test_abort();
      int  got, cyc, lat;
      bit  tmo, seen;
      num_terms = 9'd4;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      got = 0;
      cyc = 0;
      while (got < 2 && cyc < 20) begin
         in_valid = 1'b1;
         a = 8'($urandom);
         b = 8'($urandom);
         if (in_ready) got++;
         @(posedge clk); #1;
         cyc++;
      end
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      in_valid = 1'b0;
      n_tests++;
      if ({busy, in_ready, out_valid} !== 3'b000) begin
         n_fail++;
         $display("FAIL abort_idle: got %b expected 000", {busy, in_ready, out_valid});
      end
      seen = 1'b0;
      repeat (5) begin
         if (out_valid) seen = 1'b1;
         @(posedge clk); #1;
      end
      n_tests++;
      if (seen !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_no_valid: got out_valid seen=%0d expected 0", seen);
      end
      pa[0] = 10; pb[0] = 10;
      drive_run(1, 1'b0, lat, tmo);
      n_tests++;
      if (tmo !== 1'b0 || result !== 24'd100 || overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_rerun: got %0d ovf=%0d expected 100 ovf=0", result, overflow);
      end
      // abort together with out_ready in DONE
      abort = 1'b1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      out_ready = 1'b0;
      n_tests++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_done: got ov=%0d busy=%0d expected 0 0", out_valid, busy);
      end
   endtask

   task automatic test_random();
      int     n, lat;
      bit     tmo, o24, o16s, o16w;
      longint r24, r16s, r16w;
      for (int run = 0; run < 8; run++) begin
         n = $urandom_range(1, 24);
         for (int i = 0; i < n; i++) begin
            pa[i] = ($urandom_range(0, 3) == 0) ? 255 : int'($urandom_range(0, 255));
            pb[i] = int'($urandom_range(0, 255));
         end
         model(n, 24, 1'b1, r24, o24);
         model(n, 16, 1'b1, r16s, o16s);
         model(n, 16, 1'b0, r16w, o16w);
         drive_run(n, run[0], lat, tmo);
         n_tests++;
         if (tmo !== 1'b0 || lat != 2) begin
            n_fail++;
            $display("FAIL rand_latency run %0d: got lat=%0d tmo=%0d expected 2 0", run, lat, tmo);
         end
         n_tests++;
         if (result !== 24'(r24) || overflow !== o24) begin
            n_fail++;
            $display("FAIL rand_acc24 run %0d: got %0d/%0d expected %0d/%0d", run, result, overflow, r24, o24);
         end
         n_tests++;
         if (result_s !== 16'(r16s) || overflow_s !== o16s || result_w !== 16'(r16w) || overflow_w !== o16w) begin
            n_fail++;
            $display("FAIL rand_acc16 run %0d: got sat %0d/%0d wrap %0d/%0d expected %0d/%0d %0d/%0d",
                     run, result_s, overflow_s, result_w, overflow_w, r16s, o16s, r16w, o16w);
         end
         repeat ($urandom_range(0, 3)) begin
            @(posedge clk); #1;
         end
         handshake();
      end
   endtask

   task automatic test_reset_mid_run();
      int     lat;
      bit     tmo, o16s, o16w, o24;
      longint r16s, r16w, r24;
      num_terms = 9'd5;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      in_valid = 1'b1;
      a = 8'd255;
      b = 8'd255;
      repeat (3) begin
         @(posedge clk); #1;
      end
      #2;
      rst_n = 1'b0;
      #1;
      n_tests++;
      if ({in_ready, out_valid, overflow, busy} !== 4'b0000 || result !== 24'd0) begin
         n_fail++;
         $display("FAIL async_reset: got flags=%b res=%0d expected 0000 0",
                  {in_ready, out_valid, overflow, busy}, result);
      end
      in_valid = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < MAX_TERMS; i++) begin
         pa[i] = 255;
         pb[i] = 255;
      end
      model(MAX_TERMS, 24, 1'b1, r24, o24);
      model(MAX_TERMS, 16, 1'b1, r16s, o16s);
      model(MAX_TERMS, 16, 1'b0, r16w, o16w);
      drive_run(MAX_TERMS, 1'b0, lat, tmo);
      n_tests++;
      if (tmo !== 1'b0 || result !== 24'd16646400 || overflow !== 1'b0 || result !== 24'(r24)) begin
         n_fail++;
         $display("FAIL full_run24: got %0d ovf=%0d tmo=%0d expected 16646400 ovf=0", result, overflow, tmo);
      end
      n_tests++;
      if (result_s !== 16'(r16s) || overflow_s !== o16s || result_w !== 16'(r16w) || overflow_w !== o16w) begin
         n_fail++;
         $display("FAIL full_run16: got sat %0d/%0d wrap %0d/%0d expected %0d/%0d %0d/%0d",
                  result_s, overflow_s, result_w, overflow_w, r16s, o16s, r16w, o16w);
      end
      handshake();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_back_to_back();
      test_gaps_and_hold();
      test_saturate();
      test_zero_terms();
      test_abort();
      test_random();
      test_reset_mid_run();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
